// File: rtl/idu_rf_pkg.sv
// Shared widths and helpers for the register-read stage.
// The priority helper takes a fixed-width vector so every bypass count up to RF_MAX_FWD can use it.
package idu_rf_pkg;

    localparam int RF_DATA_W  = 64;
    localparam int RF_PREG_W  = 6;
    localparam int RF_IID_W   = 5;
    localparam int RF_NUM_SRC = 2;
    localparam int RF_NUM_FWD = 8;
    localparam int RF_MAX_FWD = 32;

    // Isolates the lowest set bit. Bit 0 is the youngest producer, so it wins.
    function automatic logic [RF_MAX_FWD-1:0] lsb_first_onehot(input logic [RF_MAX_FWD-1:0] req);
        return req & (~req + RF_MAX_FWD'(1));
    endfunction

endpackage

// File: rtl/idu_rf_if.sv
// Issue / RF / bypass / EX signal bundle of the register-read stage.
// The slave modport is the stage itself; the master modport is its environment.
interface idu_rf_if
    import idu_rf_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int PREG_W  = RF_PREG_W,
    parameter int IID_W   = RF_IID_W,
    parameter int NUM_SRC = RF_NUM_SRC,
    parameter int NUM_FWD = RF_NUM_FWD
);

    logic                        rtu_global_flush;
    logic                        in_vld;
    logic                        in_rdy;
    logic [IID_W-1:0]            in_iid;
    logic [6:0]                  in_opcode;
    logic [6:0]                  in_funct7;
    logic [2:0]                  in_funct3;
    logic [NUM_SRC-1:0]          in_psrc_vld;
    logic [NUM_SRC*PREG_W-1:0]   in_psrc;
    logic                        in_pdst_vld;
    logic [PREG_W-1:0]           in_pdst;

    logic [NUM_SRC-1:0]          x_rf_preg_psrc_vld;
    logic [NUM_SRC*PREG_W-1:0]   x_rf_preg_psrc;
    logic [NUM_SRC*DATA_W-1:0]   x_rf_psrc_value;

    logic [NUM_FWD-1:0]          fwd_vld;
    logic [NUM_FWD*PREG_W-1:0]   fwd_preg;
    logic [NUM_FWD*DATA_W-1:0]   fwd_result;

    logic                        out_vld;
    logic                        out_rdy;
    logic [IID_W-1:0]            out_iid;
    logic [6:0]                  out_opcode;
    logic [6:0]                  out_funct7;
    logic [2:0]                  out_funct3;
    logic                        out_pdst_vld;
    logic [PREG_W-1:0]           out_pdst;
    logic [NUM_SRC-1:0]          out_psrc_vld;
    logic [NUM_SRC*DATA_W-1:0]   out_psrc_value;
    logic                        out_div_stall;

    modport slave (
        input  rtu_global_flush, in_vld, in_iid, in_opcode, in_funct7, in_funct3,
               in_psrc_vld, in_psrc, in_pdst_vld, in_pdst,
               x_rf_psrc_value, fwd_vld, fwd_preg, fwd_result, out_rdy,
        output in_rdy, x_rf_preg_psrc_vld, x_rf_preg_psrc,
               out_vld, out_iid, out_opcode, out_funct7, out_funct3,
               out_pdst_vld, out_pdst, out_psrc_vld, out_psrc_value, out_div_stall
    );

    modport master (
        output rtu_global_flush, in_vld, in_iid, in_opcode, in_funct7, in_funct3,
               in_psrc_vld, in_psrc, in_pdst_vld, in_pdst,
               x_rf_psrc_value, fwd_vld, fwd_preg, fwd_result, out_rdy,
        input  in_rdy, x_rf_preg_psrc_vld, x_rf_preg_psrc,
               out_vld, out_iid, out_opcode, out_funct7, out_funct3,
               out_pdst_vld, out_pdst, out_psrc_vld, out_psrc_value, out_div_stall
    );

endinterface

// File: rtl/idu_rf_fwd_sel.sv
// Resolves one source operand from the bypass channels or the RF read data.
// Channels are not assumed one-hot; the lowest-index match wins.
module idu_rf_fwd_sel
    import idu_rf_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int PREG_W  = RF_PREG_W,
    parameter int NUM_FWD = RF_NUM_FWD
) (
    input  logic                      psrc_vld_i,
    input  logic [PREG_W-1:0]         psrc_i,
    input  logic [DATA_W-1:0]         rf_value_i,
    input  logic [NUM_FWD-1:0]        fwd_vld_i,
    input  logic [NUM_FWD*PREG_W-1:0] fwd_preg_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_result_i,
    output logic [DATA_W-1:0]         value_o
);

    logic [RF_MAX_FWD-1:0] hit_ext;
    logic [RF_MAX_FWD-1:0] sel;
    logic [DATA_W-1:0]     fwd_val;

    always_comb begin
        hit_ext = '0;
        for (int f = 0; f < NUM_FWD; f++) begin
            hit_ext[f] = fwd_vld_i[f] & (fwd_preg_i[f*PREG_W +: PREG_W] == psrc_i);
        end
    end

    assign sel = lsb_first_onehot(hit_ext);

    always_comb begin
        fwd_val = '0;
        for (int f = 0; f < NUM_FWD; f++) begin
            if (sel[f]) fwd_val = fwd_result_i[f*DATA_W +: DATA_W];
        end
    end

    // An unused source reads as zero so stale RF data never leaks into EX.
    assign value_o = !psrc_vld_i ? '0 : ((|sel) ? fwd_val : rf_value_i);

endmodule

// File: rtl/idu_rf_stage.sv
// Register-read stage: single-entry uop buffer with valid/ready, RF address drive,
// per-source bypass resolution, and operand capture while stalled.
module idu_rf_stage
    import idu_rf_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int PREG_W  = RF_PREG_W,
    parameter int IID_W   = RF_IID_W,
    parameter int NUM_SRC = RF_NUM_SRC,
    parameter int NUM_FWD = RF_NUM_FWD
) (
    input  logic      clk,
    input  logic      rst_clk,
    idu_rf_if.slave   bus
);

    logic                      vld_q,      vld_d;
    logic [IID_W-1:0]          iid_q,      iid_d;
    logic [6:0]                opcode_q,   opcode_d;
    logic [6:0]                funct7_q,   funct7_d;
    logic [2:0]                funct3_q,   funct3_d;
    logic [NUM_SRC-1:0]        psrc_vld_q, psrc_vld_d;
    logic [NUM_SRC*PREG_W-1:0] psrc_q,     psrc_d;
    logic                      pdst_vld_q, pdst_vld_d;
    logic [PREG_W-1:0]         pdst_q,     pdst_d;
    logic [NUM_SRC-1:0]        cap_q,      cap_d;
    logic [NUM_SRC*DATA_W-1:0] capval_q,   capval_d;

    logic                      load;
    logic                      fire;
    logic [NUM_SRC*DATA_W-1:0] resolved;

    assign bus.in_rdy = !vld_q | bus.out_rdy;
    assign load       = bus.in_vld & bus.in_rdy & !bus.rtu_global_flush;
    assign fire       = vld_q & bus.out_rdy;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        idu_rf_fwd_sel #(
            .DATA_W  (DATA_W),
            .PREG_W  (PREG_W),
            .NUM_FWD (NUM_FWD)
        ) u_fwd_sel (
            .psrc_vld_i   (psrc_vld_q[s]),
            .psrc_i       (psrc_q[s*PREG_W +: PREG_W]),
            .rf_value_i   (bus.x_rf_psrc_value[s*DATA_W +: DATA_W]),
            .fwd_vld_i    (bus.fwd_vld),
            .fwd_preg_i   (bus.fwd_preg),
            .fwd_result_i (bus.fwd_result),
            .value_o      (resolved[s*DATA_W +: DATA_W])
        );

        assign bus.out_psrc_value[s*DATA_W +: DATA_W] =
            cap_q[s] ? capval_q[s*DATA_W +: DATA_W] : resolved[s*DATA_W +: DATA_W];
    end

    always_comb begin
        vld_d      = vld_q;
        iid_d      = iid_q;
        opcode_d   = opcode_q;
        funct7_d   = funct7_q;
        funct3_d   = funct3_q;
        psrc_vld_d = psrc_vld_q;
        psrc_d     = psrc_q;
        pdst_vld_d = pdst_vld_q;
        pdst_d     = pdst_q;
        cap_d      = cap_q;
        capval_d   = capval_q;

        if (load) begin
            // Also covers fire-and-load: the new uop simply replaces the old one.
            vld_d      = 1'b1;
            iid_d      = bus.in_iid;
            opcode_d   = bus.in_opcode;
            funct7_d   = bus.in_funct7;
            funct3_d   = bus.in_funct3;
            psrc_vld_d = bus.in_psrc_vld;
            psrc_d     = bus.in_psrc;
            pdst_vld_d = bus.in_pdst_vld;
            pdst_d     = bus.in_pdst;
            cap_d      = '0;
            capval_d   = '0;
        end else if (bus.rtu_global_flush || fire) begin
            vld_d      = 1'b0;
            iid_d      = '0;
            opcode_d   = '0;
            funct7_d   = '0;
            funct3_d   = '0;
            psrc_vld_d = '0;
            psrc_d     = '0;
            pdst_vld_d = 1'b0;
            pdst_d     = '0;
            cap_d      = '0;
            capval_d   = '0;
        end else if (vld_q) begin
            // Stalled: freeze each operand once so a bypass that goes away is not lost.
            for (int s = 0; s < NUM_SRC; s++) begin
                if (!cap_q[s] && psrc_vld_q[s]) begin
                    cap_d[s]                      = 1'b1;
                    capval_d[s*DATA_W +: DATA_W] = resolved[s*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            vld_q      <= 1'b0;
            iid_q      <= '0;
            opcode_q   <= '0;
            funct7_q   <= '0;
            funct3_q   <= '0;
            psrc_vld_q <= '0;
            psrc_q     <= '0;
            pdst_vld_q <= 1'b0;
            pdst_q     <= '0;
            cap_q      <= '0;
            capval_q   <= '0;
        end else begin
            vld_q      <= vld_d;
            iid_q      <= iid_d;
            opcode_q   <= opcode_d;
            funct7_q   <= funct7_d;
            funct3_q   <= funct3_d;
            psrc_vld_q <= psrc_vld_d;
            psrc_q     <= psrc_d;
            pdst_vld_q <= pdst_vld_d;
            pdst_q     <= pdst_d;
            cap_q      <= cap_d;
            capval_q   <= capval_d;
        end
    end

    assign bus.x_rf_preg_psrc_vld = psrc_vld_q;
    assign bus.x_rf_preg_psrc     = psrc_q;
    assign bus.out_vld            = vld_q;
    assign bus.out_iid            = iid_q;
    assign bus.out_opcode         = opcode_q;
    assign bus.out_funct7         = funct7_q;
    assign bus.out_funct3         = funct3_q;
    assign bus.out_pdst_vld       = pdst_vld_q;
    assign bus.out_pdst           = pdst_q;
    assign bus.out_psrc_vld       = psrc_vld_q;
    assign bus.out_div_stall      = vld_q & funct3_q[2];

endmodule

// File: tb/tb_idu_rf_stage.sv
// Directed scenarios plus a randomized run against a uop-level reference model.
module tb_idu_rf_stage;

    localparam int DW = 64;
    localparam int PW = 6;
    localparam int NF = 8;

    logic clk = 1'b0;
    logic rst_clk = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    idu_rf_if bus ();

    idu_rf_stage dut (
        .clk     (clk),
        .rst_clk (rst_clk),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the uop held for EX, and per source whether its operand is frozen.
    logic            m_vld;
    logic [4:0]      m_iid;
    logic [6:0]      m_opc, m_f7;
    logic [2:0]      m_f3;
    logic [1:0]      m_pv;
    logic [5:0]      m_ps [2];
    logic            m_dv;
    logic [5:0]      m_pd;
    logic [1:0]      m_frozen;
    logic [63:0]     m_frozen_val [2];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rtu_global_flush = 1'b0;
        bus.in_vld           = 1'b0;
        bus.in_iid           = '0;
        bus.in_opcode        = '0;
        bus.in_funct7        = '0;
        bus.in_funct3        = '0;
        bus.in_psrc_vld      = '0;
        bus.in_psrc          = '0;
        bus.in_pdst_vld      = 1'b0;
        bus.in_pdst          = '0;
        bus.x_rf_psrc_value  = '0;
        bus.fwd_vld          = '0;
        bus.fwd_preg         = '0;
        bus.fwd_result       = '0;
        bus.out_rdy          = 1'b1;
    endtask

    task automatic drive_uop(input logic [4:0] iid, input logic [2:0] f3, input logic [1:0] pv,
                             input logic [5:0] p0, input logic [5:0] p1);
        bus.in_vld      = 1'b1;
        bus.in_iid      = iid;
        bus.in_opcode   = 7'h33;
        bus.in_funct7   = 7'h01;
        bus.in_funct3   = f3;
        bus.in_psrc_vld = pv;
        bus.in_psrc     = {p1, p0};
        bus.in_pdst_vld = 1'b1;
        bus.in_pdst     = 6'd20;
    endtask

    task automatic set_fwd(input int f, input logic [5:0] preg, input logic [63:0] val);
        bus.fwd_vld[f]             = 1'b1;
        bus.fwd_preg[f*PW +: PW]   = preg;
        bus.fwd_result[f*DW +: DW] = val;
    endtask

    function automatic logic [63:0] src_val(input int s);
        return bus.out_psrc_value[s*DW +: DW];
    endfunction

    // Spec-level operand rule: first matching bypass in priority order, else RF, zero if unused.
    function automatic logic [63:0] ref_operand(input logic v, input logic [5:0] p, input int s);
        if (!v) return 64'd0;
        for (int f = 0; f < NF; f++)
            if (bus.fwd_vld[f] && bus.fwd_preg[f*PW +: PW] == p) return bus.fwd_result[f*DW +: DW];
        return bus.x_rf_psrc_value[s*DW +: DW];
    endfunction

    task automatic test_reset();
        idle();
        #2;
        n_checks++;
        if ({bus.out_vld, bus.in_rdy, bus.x_rf_preg_psrc_vld, bus.out_div_stall} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_outputs got vld/rdy/rfvld/div=%b required 01000",
                     {bus.out_vld, bus.in_rdy, bus.x_rf_preg_psrc_vld, bus.out_div_stall});
        end
        n_checks++;
        if (bus.out_psrc_value !== '0 || bus.out_iid !== '0) begin
            n_fail++;
            $display("FAIL reset_fields got value=%h iid=%0d required 0", bus.out_psrc_value, bus.out_iid);
        end
        @(negedge clk);
        rst_clk = 1'b1;
        next_cycle();
    endtask

    task automatic test_plain_issue();
        idle();
        drive_uop(5'd3, 3'd0, 2'b11, 6'd5, 6'd7);
        next_cycle();
        idle();
        bus.x_rf_psrc_value = {64'hB, 64'hA};
        @(negedge clk);
        n_checks++;
        if (bus.out_vld !== 1'b1 || bus.in_rdy !== 1'b1 || bus.out_iid !== 5'd3) begin
            n_fail++;
            $display("FAIL plain_handshake got vld=%b rdy=%b iid=%0d required 1 1 3",
                     bus.out_vld, bus.in_rdy, bus.out_iid);
        end
        n_checks++;
        if (src_val(0) !== 64'hA || src_val(1) !== 64'hB) begin
            n_fail++;
            $display("FAIL plain_values got %h/%h required a/b", src_val(0), src_val(1));
        end
        n_checks++;
        if (bus.x_rf_preg_psrc !== {6'd7, 6'd5} || bus.x_rf_preg_psrc_vld !== 2'b11) begin
            n_fail++;
            $display("FAIL plain_rf_addr got %h vld=%b required 1c5 vld=11",
                     bus.x_rf_preg_psrc, bus.x_rf_preg_psrc_vld);
        end
        next_cycle();
        n_checks++;
        if (bus.out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL plain_drain got out_vld=%b required 0", bus.out_vld);
        end
    endtask

    task automatic test_priority();
        idle();
        drive_uop(5'd6, 3'd0, 2'b11, 6'd5, 6'd7);
        next_cycle();
        idle();
        bus.out_rdy = 1'b0;
        bus.x_rf_psrc_value = {64'h7777_0000, 64'h5555_0000};
        set_fwd(2, 6'd5, 64'h22);
        set_fwd(5, 6'd5, 64'h55);
        @(negedge clk);
        n_checks++;
        if (src_val(0) !== 64'h22 || src_val(1) !== 64'h7777_0000) begin
            n_fail++;
            $display("FAIL prio_two_hits got %h/%h required 22/77770000", src_val(0), src_val(1));
        end
        #1;
        bus.fwd_vld[2] = 1'b0;
        #1;
        n_checks++;
        if (src_val(0) !== 64'h55) begin
            n_fail++;
            $display("FAIL prio_drop_high got %h required 55", src_val(0));
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (src_val(0) !== 64'h55 || bus.out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_captured got %h vld=%b required 55 vld=1", src_val(0), bus.out_vld);
        end
        next_cycle();
    endtask

    task automatic test_stall_capture();
        idle();
        bus.out_rdy = 1'b0;
        drive_uop(5'd4, 3'd0, 2'b11, 6'd3, 6'd7);
        next_cycle();
        idle();
        bus.out_rdy = 1'b0;
        set_fwd(0, 6'd7, 64'h77);
        bus.x_rf_psrc_value = {64'h99, 64'h1234};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (src_val(1) !== 64'h77 || src_val(0) !== 64'h1234) begin
                n_fail++;
                $display("FAIL stall_value c%0d got %h/%h required 1234/77", c, src_val(0), src_val(1));
            end
            n_checks++;
            if (bus.in_rdy !== (c == 2) || bus.out_vld !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_rdy c%0d got rdy=%b vld=%b required rdy=%0d vld=1",
                         c, bus.in_rdy, bus.out_vld, (c == 2));
            end
            next_cycle();
            idle();
            bus.out_rdy = (c == 1);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release got out_vld=%b required 0", bus.out_vld);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        // The first uop is held one cycle so it freezes a value; the next loads must not inherit it.
        idle();
        bus.out_rdy = 1'b0;
        drive_uop(5'd1, 3'd0, 2'b01, 6'd9, 6'd0);
        next_cycle();
        idle();
        bus.out_rdy = 1'b0;
        bus.x_rf_psrc_value = {64'h0, 64'h100};
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            idle();
            if (k < 2) drive_uop(5'(k + 2), 3'd0, 2'b01, 6'd9, 6'd0);
            bus.x_rf_psrc_value = {64'h0, 64'(64'h100 + 64'(k * 16))};
            @(negedge clk);
            n_checks++;
            if (bus.out_vld !== 1'b1 || bus.out_iid !== 5'(k + 1) || bus.in_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_order k%0d got vld=%b iid=%0d rdy=%b required 1 %0d 1",
                         k, bus.out_vld, bus.out_iid, bus.in_rdy, k + 1);
            end
            n_checks++;
            if (src_val(0) !== 64'(64'h100 + 64'(k * 16))) begin
                n_fail++;
                $display("FAIL b2b_cap_clear k%0d got %h required %h", k, src_val(0), 64'h100 + k * 16);
            end
            next_cycle();
        end
        idle();
        @(negedge clk);
        n_checks++;
        if (bus.out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain got out_vld=%b required 0", bus.out_vld);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        idle();
        bus.out_rdy = 1'b0;
        drive_uop(5'd12, 3'd4, 2'b11, 6'd1, 6'd2);
        next_cycle();
        idle();
        bus.out_rdy = 1'b0;
        bus.rtu_global_flush = 1'b1;
        drive_uop(5'd9, 3'd0, 2'b11, 6'd3, 6'd4);
        @(negedge clk);
        n_checks++;
        if (bus.out_vld !== 1'b1 || bus.in_rdy !== 1'b0 || bus.out_div_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre got vld=%b rdy=%b div=%b required 1 0 1",
                     bus.out_vld, bus.in_rdy, bus.out_div_stall);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if ({bus.out_vld, bus.out_iid, bus.out_pdst_vld, bus.out_pdst, bus.x_rf_preg_psrc_vld,
             bus.out_funct3} !== '0) begin
            n_fail++;
            $display("FAIL flush_clear got vld=%b iid=%0d pdst=%0d rfvld=%b f3=%0d required all 0",
                     bus.out_vld, bus.out_iid, bus.out_pdst, bus.x_rf_preg_psrc_vld, bus.out_funct3);
        end
        next_cycle();
    endtask

    task automatic test_async_reset_invalid_src();
        idle();
        bus.out_rdy = 1'b0;
        drive_uop(5'd15, 3'd0, 2'b11, 6'd1, 6'd2);
        next_cycle();
        idle();
        bus.out_rdy = 1'b0;
        @(negedge clk);
        #1;
        rst_clk = 1'b0;
        #1;
        n_checks++;
        if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1 || bus.out_iid !== '0) begin
            n_fail++;
            $display("FAIL async_reset got vld=%b rdy=%b iid=%0d required 0 1 0",
                     bus.out_vld, bus.in_rdy, bus.out_iid);
        end
        @(negedge clk);
        rst_clk = 1'b1;
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            idle();
            drive_uop(5'd8, (k == 0) ? 3'd4 : 3'd1, 2'b10, 6'd4, 6'd4);
            next_cycle();
            idle();
            set_fwd(1, 6'd4, 64'h44);
            bus.x_rf_psrc_value = {64'hEE, 64'hDD};
            @(negedge clk);
            n_checks++;
            if (src_val(0) !== 64'h0 || src_val(1) !== 64'h44) begin
                n_fail++;
                $display("FAIL invalid_src k%0d got %h/%h required 0/44", k, src_val(0), src_val(1));
            end
            n_checks++;
            if (bus.out_div_stall !== (k == 0)) begin
                n_fail++;
                $display("FAIL div_stall k%0d got %b required %0d", k, bus.out_div_stall, (k == 0));
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic [63:0] exp_v;
        logic        acc;
        idle();
        next_cycle();
        m_vld = 1'b0; m_iid = '0; m_opc = '0; m_f7 = '0; m_f3 = '0; m_pv = '0;
        m_ps[0] = '0; m_ps[1] = '0; m_dv = 1'b0; m_pd = '0; m_frozen = '0;
        m_frozen_val[0] = '0; m_frozen_val[1] = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.rtu_global_flush = ($urandom_range(0, 19) == 0);
            bus.in_vld      = ($urandom_range(0, 9) < 7);
            bus.out_rdy     = ($urandom_range(0, 9) < 6);
            bus.in_iid      = 5'($urandom);
            bus.in_opcode   = 7'($urandom);
            bus.in_funct7   = 7'($urandom);
            bus.in_funct3   = 3'($urandom);
            bus.in_psrc_vld = 2'($urandom);
            bus.in_psrc     = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            bus.in_pdst_vld = 1'($urandom);
            bus.in_pdst     = 6'($urandom);
            bus.x_rf_psrc_value = {$urandom, $urandom, $urandom, $urandom};
            bus.fwd_vld     = 8'($urandom);
            for (int f = 0; f < NF; f++) begin
                bus.fwd_preg[f*PW +: PW]   = 6'($urandom_range(0, 7));
                bus.fwd_result[f*DW +: DW] = {$urandom, $urandom};
            end
            @(negedge clk);
            n_checks++;
            if (bus.out_vld !== m_vld || bus.in_rdy !== (!m_vld || bus.out_rdy)) begin
                n_fail++;
                $display("FAIL rnd_hs cyc%0d got vld=%b rdy=%b required vld=%b rdy=%b",
                         cyc, bus.out_vld, bus.in_rdy, m_vld, (!m_vld || bus.out_rdy));
            end
            n_checks++;
            if ({bus.out_iid, bus.out_opcode, bus.out_funct7, bus.out_funct3, bus.out_pdst_vld,
                 bus.out_pdst, bus.x_rf_preg_psrc_vld, bus.x_rf_preg_psrc, bus.out_div_stall} !==
                {m_iid, m_opc, m_f7, m_f3, m_dv, m_pd, m_pv, m_ps[1], m_ps[0], m_vld & m_f3[2]}) begin
                n_fail++;
                $display("FAIL rnd_fields cyc%0d got iid=%0d f3=%0d pdst=%0d psrc=%h required iid=%0d f3=%0d pdst=%0d psrc=%h",
                         cyc, bus.out_iid, bus.out_funct3, bus.out_pdst, bus.x_rf_preg_psrc,
                         m_iid, m_f3, m_pd, {m_ps[1], m_ps[0]});
            end
            for (int s = 0; s < 2; s++) begin
                exp_v = m_frozen[s] ? m_frozen_val[s] : ref_operand(m_pv[s], m_ps[s], s);
                n_checks++;
                if (src_val(s) !== exp_v) begin
                    n_fail++;
                    $display("FAIL rnd_operand cyc%0d src%0d got %h required %h", cyc, s, src_val(s), exp_v);
                end
            end
            acc = bus.in_vld && (!m_vld || bus.out_rdy) && !bus.rtu_global_flush;
            if (acc) begin
                m_vld = 1'b1; m_iid = bus.in_iid; m_opc = bus.in_opcode; m_f7 = bus.in_funct7;
                m_f3 = bus.in_funct3; m_pv = bus.in_psrc_vld; m_ps[0] = bus.in_psrc[5:0];
                m_ps[1] = bus.in_psrc[11:6]; m_dv = bus.in_pdst_vld; m_pd = bus.in_pdst;
                m_frozen = '0;
            end else if (bus.rtu_global_flush || (m_vld && bus.out_rdy)) begin
                m_vld = 1'b0; m_iid = '0; m_opc = '0; m_f7 = '0; m_f3 = '0; m_pv = '0;
                m_ps[0] = '0; m_ps[1] = '0; m_dv = 1'b0; m_pd = '0; m_frozen = '0;
            end else if (m_vld) begin
                for (int s = 0; s < 2; s++) begin
                    if (m_pv[s] && !m_frozen[s]) begin
                        m_frozen_val[s] = ref_operand(1'b1, m_ps[s], s);
                        m_frozen[s] = 1'b1;
                    end
                end
            end
            next_cycle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_plain_issue();
        test_priority();
        test_stall_capture();
        test_back_to_back();
        test_flush();
        test_async_reset_invalid_src();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
